// File: rtl/rxshift.sv
// ============================================================================
// Module   : rxshift
// Brief    : 8N1 receive shift register with mid-bit sampling, glitch-start
//            rejection and stop-bit framing-error detection.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module rxshift (
    input  logic        i_Pclk,
    input  logic        i_Reset,
    input  logic [13:0] i_Baud,
    input  logic        i_Enable,
    input  logic        i_Rx_Serial,
    output logic [7:0]  o_Data,
    output logic        o_Valid,
    output logic        o_Frame_Err,
    output logic        o_Busy
);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_START     = 3'd1,
        S_DATA      = 3'd2,
        S_STOP      = 3'd3,
        S_WAIT_HIGH = 3'd4
    } state_t;

    localparam logic [13:0] c_MIN_BAUD = 14'd4;

    state_t      r_state;
    logic        r_sync1;
    logic        r_rx_s;
    logic [13:0] r_baud;
    logic [13:0] r_cnt;
    logic [2:0]  r_bit_idx;
    logic [7:0]  r_shift;

    logic [13:0] w_half_m1;
    logic [13:0] w_baud_m1;
    logic        w_baud_ok;

    assign w_half_m1 = (r_baud >> 1) - 14'd1;
    assign w_baud_m1 = r_baud - 14'd1;
    assign w_baud_ok = (i_Baud >= c_MIN_BAUD);

    always_ff @(posedge i_Pclk) begin
        if (i_Reset) begin
            r_state     <= S_IDLE;
            r_sync1     <= 1'b1;
            r_rx_s      <= 1'b1;
            r_baud      <= 14'd0;
            r_cnt       <= 14'd0;
            r_bit_idx   <= 3'd0;
            r_shift     <= 8'h00;
            o_Data      <= 8'h00;
            o_Valid     <= 1'b0;
            o_Frame_Err <= 1'b0;
            o_Busy      <= 1'b0;
        end else begin
            r_sync1     <= i_Rx_Serial;
            r_rx_s      <= r_sync1;
            o_Valid     <= 1'b0;
            o_Frame_Err <= 1'b0;

            case (r_state)
                S_IDLE: begin
                    r_cnt     <= 14'd0;
                    r_bit_idx <= 3'd0;
                    if (i_Enable && !r_rx_s && w_baud_ok) begin
                        r_baud  <= i_Baud;
                        r_state <= S_START;
                        o_Busy  <= 1'b1;
                    end
                end

                // Re-check the line half a bit in; a high here was a glitch.
                S_START: begin
                    if (r_cnt == w_half_m1) begin
                        r_cnt <= 14'd0;
                        if (!r_rx_s) begin
                            r_state <= S_DATA;
                        end else begin
                            r_state <= S_IDLE;
                            o_Busy  <= 1'b0;
                        end
                    end else begin
                        r_cnt <= r_cnt + 14'd1;
                    end
                end

                S_DATA: begin
                    if (r_cnt == w_baud_m1) begin
                        r_cnt              <= 14'd0;
                        r_shift[r_bit_idx] <= r_rx_s;
                        if (r_bit_idx == 3'd7) begin
                            r_state <= S_STOP;
                        end else begin
                            r_bit_idx <= r_bit_idx + 3'd1;
                        end
                    end else begin
                        r_cnt <= r_cnt + 14'd1;
                    end
                end

                // Leaving at mid-stop-bit leaves half a bit to catch the next start.
                S_STOP: begin
                    if (r_cnt == w_baud_m1) begin
                        r_cnt     <= 14'd0;
                        r_bit_idx <= 3'd0;
                        if (r_rx_s) begin
                            o_Data  <= r_shift;
                            o_Valid <= 1'b1;
                            r_state <= S_IDLE;
                            o_Busy  <= 1'b0;
                        end else begin
                            o_Frame_Err <= 1'b1;
                            r_state     <= S_WAIT_HIGH;
                        end
                    end else begin
                        r_cnt <= r_cnt + 14'd1;
                    end
                end

                S_WAIT_HIGH: begin
                    if (r_rx_s) begin
                        r_state <= S_IDLE;
                        o_Busy  <= 1'b0;
                    end
                end

                default: begin
                    r_state <= S_IDLE;
                    o_Busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_rxshift.sv
// ============================================================================
// Module   : tb_rxshift
// Brief    : Self-checking bench for rxshift: frame table plus corner sequences.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_rxshift;

    logic        clk;
    logic        i_Reset;
    logic [13:0] i_Baud;
    logic        i_Enable;
    logic        i_Rx_Serial;
    logic [7:0]  o_Data;
    logic        o_Valid;
    logic        o_Frame_Err;
    logic        o_Busy;

    rxshift u_dut (
        .i_Pclk      (clk),
        .i_Reset     (i_Reset),
        .i_Baud      (i_Baud),
        .i_Enable    (i_Enable),
        .i_Rx_Serial (i_Rx_Serial),
        .o_Data      (o_Data),
        .o_Valid     (o_Valid),
        .o_Frame_Err (o_Frame_Err),
        .o_Busy      (o_Busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        bit         is_err;
        logic [7:0] data;
        int         cyc;
    } exp_t;

    typedef struct {
        logic [7:0] data;
        int         baud;
        bit         stop_ok;
    } vec_t;

    exp_t       sb[$];
    int         checks   = 0;
    int         failures = 0;
    logic [7:0] last_good = 8'h00;
    bit         busy_watch = 1'b0;
    bit         busy_seen  = 1'b0;

    task automatic check(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s: got=0x%0h expected=0x%0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Output monitor: every pulse must match the oldest pending expectation.
    always @(negedge clk) begin
        if (busy_watch && o_Busy) busy_seen = 1'b1;
        if (o_Valid && o_Frame_Err) check("valid_and_ferr_together", 1, 0);
        if (o_Valid || o_Frame_Err) begin
            if (sb.size() == 0) begin
                check("unexpected_pulse", {o_Valid, o_Frame_Err}, 0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("pulse_kind_ferr", o_Frame_Err, e.is_err);
                check("pulse_cycle", cyc, e.cyc);
                if (e.is_err) begin
                    check("ferr_data_held", o_Data, last_good);
                end else begin
                    check("rx_data", o_Data, e.data);
                    last_good = e.data;
                end
            end
        end
    end

    // kind: 0 no pulse expected, 1 valid, 2 framing error.
    // Leaves the line at the stop-bit level when it returns.
    task automatic send_frame(input logic [7:0] d, input int baud, input bit stop_ok,
                              input int kind, input int drop_bit);
        exp_t e;
        i_Baud      = 14'(baud);
        i_Rx_Serial = 1'b0;
        e.is_err = (kind == 2);
        e.data   = d;
        e.cyc    = cyc + 1 + 2 + baud / 2 + 9 * baud;
        if (kind != 0) sb.push_back(e);
        repeat (baud) tick();
        for (int i = 0; i < 8; i++) begin
            if (i == drop_bit) begin
                i_Enable = 1'b0;
                i_Baud   = 14'd9;
            end
            i_Rx_Serial = d[i];
            repeat (baud) tick();
        end
        i_Rx_Serial = stop_ok;
        repeat (baud) tick();
    endtask

    task automatic drain(input string name);
        repeat (20) tick();
        check(name, sb.size(), 0);
        sb.delete();
    endtask

    vec_t vecs[7];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{8'hA5, 16, 1'b1};
        vecs[1] = '{8'h00, 16, 1'b1};
        vecs[2] = '{8'hFF, 16, 1'b1};
        vecs[3] = '{8'h3C, 16, 1'b1};
        vecs[4] = '{8'hC3,  4, 1'b1};
        vecs[5] = '{8'h96,  5, 1'b1};
        vecs[6] = '{8'h69, 16, 1'b1};

        i_Reset     = 1'b1;
        i_Baud      = 14'd16;
        i_Enable    = 1'b1;
        i_Rx_Serial = 1'b1;
        repeat (4) tick();
        i_Reset = 1'b0;
        tick();
        check("reset_data",  o_Data, 8'h00);
        check("reset_valid", o_Valid, 0);
        check("reset_ferr",  o_Frame_Err, 0);
        check("reset_busy",  o_Busy, 0);

        // Back-to-back frames, including minimum and odd bit periods.
        for (int i = 0; i < 7; i++) begin
            send_frame(vecs[i].data, vecs[i].baud, vecs[i].stop_ok, 1, -1);
        end
        drain("table_pending");
        check("table_busy_idle", o_Busy, 0);

        // Glitch start: 3 low cycles on an idle line.
        i_Baud      = 14'd16;
        i_Rx_Serial = 1'b0;
        repeat (3) tick();
        i_Rx_Serial = 1'b1;
        check("glitch_busy_start", o_Busy, 1);
        repeat (10) tick();
        check("glitch_back_idle", o_Busy, 0);
        repeat (10) tick();
        send_frame(8'h5A, 16, 1'b1, 1, -1);
        drain("glitch_pending");

        // Unsupported bit period: a low line is ignored.
        i_Baud      = 14'd3;
        i_Rx_Serial = 1'b0;
        repeat (20) tick();
        check("baud3_busy", o_Busy, 0);
        i_Rx_Serial = 1'b1;
        repeat (5) tick();

        // Framing error followed by a held-low line.
        send_frame(8'h81, 16, 1'b0, 2, -1);
        repeat (40) tick();
        check("wait_high_busy", o_Busy, 1);
        i_Rx_Serial = 1'b1;
        repeat (4) tick();
        check("wait_high_release", o_Busy, 0);
        send_frame(8'h42, 16, 1'b1, 1, -1);
        drain("ferr_pending");

        // Reset during data bit 3.
        i_Baud      = 14'd16;
        i_Rx_Serial = 1'b0;
        repeat (16) tick();
        i_Rx_Serial = 1'b1;
        repeat (48) tick();
        i_Rx_Serial = 1'b0;
        repeat (8) tick();
        check("pre_reset_busy", o_Busy, 1);
        i_Reset     = 1'b1;
        i_Rx_Serial = 1'b1;
        tick();
        check("midreset_data",  o_Data, 8'h00);
        check("midreset_valid", o_Valid, 0);
        check("midreset_ferr",  o_Frame_Err, 0);
        check("midreset_busy",  o_Busy, 0);
        last_good = 8'h00;
        i_Reset   = 1'b0;
        repeat (5) tick();
        send_frame(8'h99, 16, 1'b1, 1, -1);
        drain("reset_pending");

        // Enable dropped mid-frame (and bit period changed): frame still completes.
        send_frame(8'h7E, 16, 1'b1, 1, 5);
        drain("enable_drop_pending");
        check("enable_drop_data", o_Data, 8'h7E);
        busy_watch = 1'b1;
        send_frame(8'h55, 16, 1'b1, 0, -1);
        repeat (20) tick();
        busy_watch = 1'b0;
        check("disabled_busy_seen", busy_seen, 0);
        check("disabled_data_held", o_Data, 8'h7E);
        drain("disabled_pending");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/rxshift.md
Name: rxshift

Overview:
- Receive shift register. It is the downstream counterpart of the transmit shift register and consumes its serial output (8N1 frame, LSB first, line idles high).
- Samples the serial line at mid-bit using the same clocks-per-bit value, i_Baud.
- Delivers the received byte with a one-cycle valid pulse toward the bus/register side.
- Detects framing errors, and rejects glitch (false) starts.

Parameters:
- none. Frame format is fixed: 1 start, 8 data, 1 stop.

Ports:
- i_Pclk  in  1  system clock; all logic on the rising edge.
- i_Reset  in  1  synchronous, active-high reset.
- i_Baud  in  14  clocks per bit; captured at start detection.
- i_Enable  in  1  allows start detection; a frame already in progress always completes.
- i_Rx_Serial  in  1  asynchronous serial input.
- o_Data  out  8  last correctly framed byte; held until the next good frame.
- o_Valid  out  1  one-cycle pulse: o_Data has just been updated.
- o_Frame_Err  out  1  one-cycle pulse: stop bit sampled low.
- o_Busy  out  1  high in every state except IDLE.

Behaviour:
- Reset values (synchronous, reset has priority over all other logic):
  - state IDLE; o_Data=0x00; o_Valid=0; o_Frame_Err=0; o_Busy=0.
  - sync flops=1; counter=0; bit index=0.
- Synchronizer: i_Rx_Serial passes through 2 flops. rx_s is the second flop's output, and all decisions use rx_s.
- Half-bit value: half = r_Baud>>1, where r_Baud is the latched i_Baud.
- Supported range: i_Baud >= 4. For i_Baud < 4 the block stays in IDLE and ignores the line.
- IDLE:
  - Counter and bit index are held at 0.
  - If i_Enable=1, rx_s=0 and i_Baud>=4: latch r_Baud, then go to START with counter=0.
- START:
  - Counter increments each cycle.
  - When counter==half-1, sample rx_s:
    - rx_s=0: counter=0, go to DATA.
    - rx_s=1: false start; go to IDLE with no pulse and no error.
- DATA:
  - Counter counts 0..r_Baud-1.
  - At r_Baud-1: shift rx_s into shift reg[bit index] and set counter=0.
  - After bit 7, go to STOP; otherwise increment bit index.
- STOP: at counter==r_Baud-1, sample rx_s:
  - rx_s=1: o_Data<=shift reg, o_Valid pulses for 1 cycle, go to IDLE.
  - rx_s=0: o_Frame_Err pulses for 1 cycle, o_Data unchanged, go to WAIT_HIGH.
- WAIT_HIGH: stay until rx_s=1, then go to IDLE. This prevents a break or low line from retriggering a start.
- Latency:
  - Let k be the first rising edge at which i_Rx_Serial=0 is captured.
  - o_Valid is registered at edge k + 2 + half + 9*r_Baud, and is high for the following cycle only.
- Back-to-back frames: the return to IDLE occurs mid-stop-bit, so a start bit immediately after the stop bit is detected without loss.
- i_Baud changes mid-frame have no effect; the new value applies from the next start detection.
- i_Enable deasserted mid-frame: the frame completes normally, including its o_Valid or o_Frame_Err pulse. No new start is accepted afterwards.
- Reset asserted mid-frame: immediate return to IDLE with reset values. No pulse is generated and the partial byte is discarded.
- o_Valid and o_Frame_Err are never high in the same cycle.

Test Plan:
1. i_Baud=16, send 0xA5 as an 8N1 frame with a clean stop bit, first low captured at edge k -> o_Valid high only in the cycle after edge k+154; o_Data=0xA5; o_Frame_Err stays 0; o_Busy returns to 0.
2. Loopback with the transmit shift register (i_Baud=16): bytes 0x00, 0xFF, 0x3C sent back to back -> three o_Valid pulses with o_Data matching each byte in order, and no o_Frame_Err.
3. i_Baud=16, low glitch of 3 cycles on an idle line -> state returns to IDLE after the half-bit check; no o_Valid, no o_Frame_Err; the next real frame 0x5A is received correctly.
4. i_Baud=16, frame 0x81 with the stop bit forced low and the line held low for 40 more cycles:
   - o_Frame_Err pulses once; o_Data keeps its previous value.
   - No new start is detected until the line goes high.
   - A following frame 0x42 is received correctly.
5. Reset asserted during data bit 3 of a frame -> all outputs at reset values on the next edge; no pulse; a following frame 0x99 is received correctly.
6. i_Enable dropped during data bit 5 of frame 0x7E -> o_Valid with o_Data=0x7E. A second frame sent while i_Enable=0 is ignored: o_Busy stays 0 and no pulse occurs.
